layer3_argmax: RTL and testbench

//  Output classifier downstream of the layer-3 neuron bank (node3_0..node3_9).
//  On a start pulse it waits for the neuron pipeline to settle, snapshots all

---
 rtl/layer3_argmax_if.sv | 25 ++
 rtl/layer3_argmax.sv | 109 ++++++++++
 tb/tb_layer3_argmax.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer3_argmax_if.sv
// Request/result bundle between the layer-3 argmax classifier and its controller/consumer.
// The master drives start, nodes and out_ready; the classifier (slave) returns status and result.
interface layer3_argmax_if #(
  parameter int unsigned NUM_NODES = 10,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned IDX_W     = 4
);
  logic                        start;
  logic [NUM_NODES*DATA_W-1:0] nodes_flat;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic [IDX_W-1:0]            class_idx;
  logic [7:0]                  class_score;

  modport master (
    output start, nodes_flat, out_ready,
    input  busy, out_valid, class_idx, class_score
  );

  modport slave (
    input  start, nodes_flat, out_ready,
    output busy, out_valid, class_idx, class_score
  );
endinterface

// File: rtl/layer3_argmax.sv
// Layer-3 output classifier: waits for the neuron bank to settle, snapshots all node outputs,
// scans them one per cycle for the largest value and hands back index/score via valid/ready.
module layer3_argmax #(
  parameter int unsigned NUM_NODES = 10,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned SETTLE    = 3
) (
  input logic             clk,
  input logic             reset,
  layer3_argmax_if.slave  bus
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StScan, StDone} state_e;

  state_e              r_state;
  logic [CntW-1:0]     r_settle_cnt;
  logic [DATA_W-1:0]   r_snap [NUM_NODES];
  logic [DATA_W-1:0]   r_best_val;
  logic [IDX_W-1:0]    r_best_idx;
  logic [IDX_W-1:0]    r_scan_idx;
  logic [IDX_W-1:0]    r_class_idx;
  logic [7:0]          r_class_score;
  logic                r_busy;
  logic                r_out_valid;

  logic [DATA_W-1:0]   w_cand;
  logic                w_take;
  logic [DATA_W-1:0]   w_next_val;
  logic [IDX_W-1:0]    w_next_idx;
  logic                w_last;
  logic                w_settled;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_cand     = r_snap[r_scan_idx];
    w_take     = (w_cand > r_best_val);
    w_next_val = w_take ? w_cand : r_best_val;
    w_next_idx = w_take ? r_scan_idx : r_best_idx;
    w_last     = (r_scan_idx == IDX_W'(NUM_NODES - 1));
    w_settled  = (r_settle_cnt == CntW'(SETTLE - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_settle_cnt  <= '0;
      r_best_val    <= '0;
      r_best_idx    <= '0;
      r_scan_idx    <= '0;
      r_class_idx   <= '0;
      r_class_score <= '0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      for (int k = 0; k < int'(NUM_NODES); k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state      <= StWait;
            r_settle_cnt <= '0;
            r_busy       <= 1'b1;
          end
        end
        StWait: begin
          if (w_settled) begin
            for (int k = 0; k < int'(NUM_NODES); k++) begin
              r_snap[k] <= bus.nodes_flat[k*DATA_W +: DATA_W];
            end
            r_best_val <= bus.nodes_flat[0 +: DATA_W];
            r_best_idx <= '0;
            r_scan_idx <= IDX_W'(1);
            r_state    <= StScan;
          end else begin
            r_settle_cnt <= r_settle_cnt + CntW'(1);
          end
        end
        StScan: begin
          r_best_val <= w_next_val;
          r_best_idx <= w_next_idx;
          r_scan_idx <= r_scan_idx + IDX_W'(1);
          if (w_last) begin
            r_class_idx   <= w_next_idx;
            r_class_score <= w_next_val[7:0];
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.out_valid   = r_out_valid;
  assign bus.class_idx   = r_class_idx;
  assign bus.class_score = r_class_score;

endmodule

// File: tb/tb_layer3_argmax.sv
// Directed bench for layer3_argmax: a reference argmax pushes expected results into a
// scoreboard queue as each request is issued; they are popped when out_valid rises.
module tb_layer3_argmax;

  localparam int unsigned NUM_NODES = 10;
  localparam int unsigned DATA_W    = 24;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned SETTLE    = 3;
  localparam int unsigned LATENCY   = SETTLE + NUM_NODES - 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [7:0]       score;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  exp_t last_res;
  logic [DATA_W-1:0] node_arr [NUM_NODES];

  layer3_argmax_if #(
    .NUM_NODES(NUM_NODES),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) bus ();

  layer3_argmax #(
    .NUM_NODES(NUM_NODES),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .SETTLE   (SETTLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_nodes();
    for (int k = 0; k < int'(NUM_NODES); k++) begin
      bus.nodes_flat[k*DATA_W +: DATA_W] = node_arr[k];
    end
  endtask

  task automatic clear_nodes();
    for (int k = 0; k < int'(NUM_NODES); k++) node_arr[k] = '0;
  endtask

  task automatic push_expected();
    exp_t e;
    logic [DATA_W-1:0] best;
    best  = node_arr[0];
    e.idx = '0;
    for (int k = 1; k < int'(NUM_NODES); k++) begin
      if (node_arr[k] > best) begin
        best  = node_arr[k];
        e.idx = IDX_W'(k);
      end
    end
    e.score = best[7:0];
    sb.push_back(e);
  endtask

  // Issue one request from IDLE and follow it to DONE, corrupting inputs after the snapshot.
  task automatic run_scan(input string tag);
    exp_t e;
    drive_nodes();
    push_expected();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= int'(LATENCY); c++) begin
      if (c < int'(LATENCY)) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (c == int'(SETTLE) + 1) check({tag, "_valid_low"}, 32'(bus.out_valid), 32'd0);
      tick();
      if (c == int'(SETTLE)) begin
        clear_nodes();
        node_arr[4] = 24'hFFFFFF;
        drive_nodes();
      end
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      last_res = e;
      check({tag, "_idx"}, 32'(bus.class_idx), 32'(e.idx));
      check({tag, "_score"}, 32'(bus.class_score), 32'(e.score));
    end
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idx_hold"}, 32'(bus.class_idx), 32'(last_res.idx));
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    last_res      = '0;
    reset         = 1'b1;
    bus.start     = 1'b1;
    bus.out_ready = 1'b0;
    clear_nodes();
    node_arr[3] = 24'd77;
    drive_nodes();

    // Reset held two cycles with start high.
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_idx", 32'(bus.class_idx), 32'd0);
    check("rst_score", 32'(bus.class_score), 32'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Basic pattern, inputs corrupted after the snapshot.
    node_arr = '{24'd10, 24'd3, 24'd31, 24'd3, 24'd5, 24'd0, 24'd0, 24'd200, 24'd19, 24'd26};
    run_scan("basic");
    check("basic_idx7", 32'(bus.class_idx), 32'd7);
    accept("basic");

    // Tie: lowest index wins.
    for (int k = 0; k < int'(NUM_NODES); k++) node_arr[k] = 24'd100;
    node_arr[2] = 24'd255;
    node_arr[5] = 24'd255;
    run_scan("tie");
    check("tie_idx2", 32'(bus.class_idx), 32'd2);
    accept("tie");

    // All zero.
    clear_nodes();
    run_scan("zero");
    accept("zero");

    // Winner in the last slot.
    clear_nodes();
    node_arr[9] = 24'd1;
    run_scan("last");
    check("last_idx9", 32'(bus.class_idx), 32'd9);
    accept("last");

    // Compare uses the full width, score is the low byte.
    clear_nodes();
    node_arr[1] = 24'h0000FF;
    node_arr[6] = 24'h010005;
    run_scan("wide");
    check("wide_score", 32'(bus.class_score), 32'h05);

    // Hold in DONE with start pulses: nothing moves.
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 1) || (c == 3);
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_busy", 32'(bus.busy), 32'd0);
      check("hold_idx", 32'(bus.class_idx), 32'(last_res.idx));
      check("hold_score", 32'(bus.class_score), 32'(last_res.score));
    end
    // Start coincident with the accepting edge is ignored too.
    bus.start = 1'b1;
    accept("hold");
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("noqueue_busy", 32'(bus.busy), 32'd0);
      check("noqueue_valid", 32'(bus.out_valid), 32'd0);
    end

    node_arr = '{24'd9, 24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1, 24'd0};
    run_scan("fresh");
    accept("fresh");

    // Reset mid-scan aborts without a result.
    node_arr = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd90, 24'd10};
    drive_nodes();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < int'(SETTLE) + 3; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_idx", 32'(bus.class_idx), 32'd0);
    check("abort_score", 32'(bus.class_score), 32'd0);
    for (int c = 0; c < int'(LATENCY); c++) begin
      tick();
      check("abort_never_valid", 32'(bus.out_valid), 32'd0);
    end
    run_scan("after_abort");
    check("after_abort_idx8", 32'(bus.class_idx), 32'd8);
    accept("after_abort");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
